// File: rtl/wshb_arbiter_if.sv
// rtl/wshb_arbiter_if.sv - Wishbone classic link bundle used by the two-master arbiter
//
// One Wishbone classic point-to-point link.
//   cyc/stb/we  : cycle, strobe, write enable (master -> slave)
//   adr [AW]    : byte address
//   sel [DW/8]  : byte selects
//   dat [DW]    : write data
//   cti [3]     : cycle type identifier
//   bte [2]     : burst type extension
//   ack         : transfer acknowledge (slave -> master)
//   rdat [DW]   : read data (slave -> master, qualify with ack)
// Modports:
//   master : the side that issues requests
//   slave  : the side that answers them
interface wshb_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    localparam int SW = DW / 8;

    logic          cyc;
    logic          stb;
    logic          we;
    logic [AW-1:0] adr;
    logic [SW-1:0] sel;
    logic [DW-1:0] dat;
    logic [2:0]    cti;
    logic [1:0]    bte;
    logic          ack;
    logic [DW-1:0] rdat;

    modport master (
        output cyc, stb, we, adr, sel, dat, cti, bte,
        input  ack, rdat
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat, cti, bte,
        output ack, rdat
    );
endinterface

// File: rtl/wshb_arbiter.sv
// rtl/wshb_arbiter.sv - two-master round-robin Wishbone classic arbiter for the SDRAM framebuffer
//
// Master 0 is the pattern/pixel writer, master 1 the display-side reader.
// A grant is held for the whole of the winner's cyc; on a tie the master
// not served last wins. Requests are muxed to the slave, ack goes back to the
// granted master only, read data is broadcast to both.
//
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   m0   : master 0 link (slave modport - the arbiter answers it)
//   m1   : master 1 link (slave modport)
//   s    : link to the SDRAM controller (master modport)
//   gnt  : one-hot current grant, 01 = m0, 10 = m1, 00 = none
//
// Optional feature: define WSHB_ARB_QUOTA_EN to revoke a grant after QUOTA
// acks when the other master is waiting (one hand-over cycle with s.cyc=0).
module wshb_arbiter #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int QUOTA = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    wshb_arbiter_if.slave        m0,
    wshb_arbiter_if.slave        m1,
    wshb_arbiter_if.master       s,
    output logic [1:0]           gnt
);
    localparam int SW = DW / 8;

    if (QUOTA < 1) begin : g_quota_check
        $error("wshb_arbiter: QUOTA must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        GNT0,
        GNT1
    } state_t;

    state_t state, state_nxt;
    // 1 = m1 served last, so a tie goes to m0 (the reset preference)
    logic   last, last_nxt;
    // quota hand-over in progress this cycle
    logic   hand;

    logic          cyc_o, stb_o, we_o;
    logic [AW-1:0] adr_o;
    logic [SW-1:0] sel_o;
    logic [DW-1:0] dat_o;
    logic [2:0]    cti_o;
    logic [1:0]    bte_o;
    logic          ack0, ack1;

`ifdef WSHB_ARB_QUOTA_EN
    localparam int CW = $clog2(QUOTA + 1);

    logic [CW-1:0] ack_cnt;
    logic          other_cyc;

    always_comb begin
        other_cyc = 1'b0;
        if (state == GNT0) other_cyc = m1.cyc;
        if (state == GNT1) other_cyc = m0.cyc;
    end

    assign hand = (ack_cnt == CW'(QUOTA)) && other_cyc;

    // Saturates at QUOTA so a lone master keeps streaming without wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_cnt <= '0;
        end else if (state_nxt != state) begin
            ack_cnt <= '0;
        end else if ((ack0 || ack1) && (ack_cnt != CW'(QUOTA))) begin
            ack_cnt <= ack_cnt + 1'b1;
        end
    end
`else
    assign hand = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (m0.cyc && (!m1.cyc || last)) state_nxt = GNT0;
                else if (m1.cyc)                 state_nxt = GNT1;
            end
            GNT0: begin
                if (!m0.cyc || hand) begin
                    last_nxt  = 1'b0;
                    state_nxt = m1.cyc ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (!m1.cyc || hand) begin
                    last_nxt  = 1'b1;
                    state_nxt = m0.cyc ? GNT0 : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are forced idle while rst is high so the slave sees cyc drop
    // in the reset cycle itself and no ack leaks to a master.
    always_comb begin
        cyc_o = 1'b0;
        stb_o = 1'b0;
        we_o  = 1'b0;
        adr_o = '0;
        sel_o = '0;
        dat_o = '0;
        cti_o = '0;
        bte_o = '0;
        ack0  = 1'b0;
        ack1  = 1'b0;
        if (!rst) begin
            case (state)
                GNT0: begin
                    cyc_o = m0.cyc & ~hand;
                    stb_o = m0.stb & ~hand;
                    we_o  = m0.we;
                    adr_o = m0.adr;
                    sel_o = m0.sel;
                    dat_o = m0.dat;
                    cti_o = m0.cti;
                    bte_o = m0.bte;
                    ack0  = s.ack & m0.stb & ~hand;
                end
                GNT1: begin
                    cyc_o = m1.cyc & ~hand;
                    stb_o = m1.stb & ~hand;
                    we_o  = m1.we;
                    adr_o = m1.adr;
                    sel_o = m1.sel;
                    dat_o = m1.dat;
                    cti_o = m1.cti;
                    bte_o = m1.bte;
                    ack1  = s.ack & m1.stb & ~hand;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        gnt = 2'b00;
        if (state == GNT0) gnt = 2'b01;
        if (state == GNT1) gnt = 2'b10;
    end

    assign s.cyc   = cyc_o;
    assign s.stb   = stb_o;
    assign s.we    = we_o;
    assign s.adr   = adr_o;
    assign s.sel   = sel_o;
    assign s.dat   = dat_o;
    assign s.cti   = cti_o;
    assign s.bte   = bte_o;
    assign m0.ack  = ack0;
    assign m1.ack  = ack1;
    assign m0.rdat = s.rdat;
    assign m1.rdat = s.rdat;
endmodule
